// File: rtl/mbist_addrseq.sv
// March-element address sequencer for memory BIST: linear, row-fast and gray orders over a bounded index range.
// Define MBIST_ADDR_RANGE_EN to honour addr_lo/addr_hi; otherwise every element sweeps the full address space.
module mbist_addrseq #(
    parameter int ADDR_WIDTH = 8,
    parameter int COL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start_elem,
    input  logic                  dir_up,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] addr_lo,
    input  logic [ADDR_WIDTH-1:0] addr_hi,
    input  logic                  addr_step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  sweep_done,
    output logic                  busy,
    output logic                  last_addr,
    output logic                  range_err
);

    localparam int ROW_W = ADDR_WIDTH - COL_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ORD_LINEAR  = 2'b00,
        ORD_ROWFAST = 2'b01,
        ORD_GRAY    = 2'b10,
        ORD_RSVD    = 2'b11
    } order_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    logic [ADDR_WIDTH-1:0] lo_eff, hi_eff;

`ifdef MBIST_ADDR_RANGE_EN
    assign lo_eff = addr_lo;
    assign hi_eff = addr_hi;
`else
    logic unused_range;
    assign lo_eff       = '0;
    assign hi_eff       = '1;
    assign unused_range = ^{addr_lo, addr_hi};
`endif

    // Row-fast swaps the row field into the low bits so consecutive indices walk down a column.
    function automatic logic [ADDR_WIDTH-1:0] map_addr(input order_e ord,
                                                       input logic [ADDR_WIDTH-1:0] i);
        case (ord)
            ORD_ROWFAST: map_addr = {i[ROW_W-1:0], i[ADDR_WIDTH-1:ROW_W]};
            ORD_GRAY:    map_addr = i ^ (i >> 1);
            default:     map_addr = i;
        endcase
    endfunction

    state_e                state_q, state_d;
    order_e                order_q, order_d;
    logic                  dir_q, dir_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] end_q, end_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  last_q, last_d;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves one unassigned (no latch).
        state_d = state_q;
        order_d = order_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        end_d   = end_q;
        addr_d  = addr_q;
        done_d  = done_q;
        err_d   = err_q;

        if (start_elem) begin
            if (lo_eff > hi_eff) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end else begin
                state_d = ST_BUSY;
                order_d = order_e'(mode);
                dir_d   = dir_up;
                idx_d   = dir_up ? lo_eff : hi_eff;
                end_d   = dir_up ? hi_eff : lo_eff;
                addr_d  = map_addr(order_e'(mode), dir_up ? lo_eff : hi_eff);
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
        end else if (state_q == ST_BUSY && addr_step) begin
            // The end bound is checked before moving, so the index never steps past either limit.
            if (idx_q == end_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                idx_d  = dir_q ? idx_q + ONE : idx_q - ONE;
                addr_d = map_addr(order_q, dir_q ? idx_q + ONE : idx_q - ONE);
            end
        end

        last_d = (state_d == ST_BUSY) && (idx_d == end_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            order_q <= ORD_LINEAR;
            dir_q   <= 1'b0;
            idx_q   <= '0;
            end_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            order_q <= order_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            end_q   <= end_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign addr       = addr_q;
    assign busy       = (state_q == ST_BUSY);
    assign sweep_done = done_q;
    assign last_addr  = last_q;
    assign range_err  = err_q;

endmodule

// File: tb/tb_mbist_addrseq.sv
// Self-checking bench for mbist_addrseq (ADDR_WIDTH=4, COL_WIDTH=2) against a sequence-list reference model.
// Expectations follow MBIST_ADDR_RANGE_EN: defined honours the bounds, undefined sweeps 0..15.
module tb_mbist_addrseq;

    localparam int AW = 4;
    localparam int CW = 2;
    localparam int RW = AW - CW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start_elem, dir_up, addr_step;
    logic [1:0]    mode;
    logic [AW-1:0] addr_lo, addr_hi;
    logic [AW-1:0] addr;
    logic          sweep_done, busy, last_addr, range_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mbist_addrseq #(.ADDR_WIDTH(AW), .COL_WIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_elem (start_elem),
        .dir_up     (dir_up),
        .mode       (mode),
        .addr_lo    (addr_lo),
        .addr_hi    (addr_hi),
        .addr_step  (addr_step),
        .addr       (addr),
        .sweep_done (sweep_done),
        .busy       (busy),
        .last_addr  (last_addr),
        .range_err  (range_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an element is the explicit list of indices it visits, walked by position.
    int       m_seq[$];
    int       m_pos;
    int       m_mode;
    bit       m_busy, m_done, m_err;
    int       m_addr;

    function automatic int ref_map(input int md, input int i);
        case (md)
            1:       return (i % (1 << RW)) * (1 << CW) + i / (1 << RW);
            2:       return i ^ (i / 2);
            default: return i;
        endcase
    endfunction

    task automatic model_reset();
        m_seq.delete();
        m_pos  = 0;
        m_mode = 0;
        m_busy = 0;
        m_done = 0;
        m_err  = 0;
        m_addr = 0;
    endtask

    task automatic model_edge(input bit st, input bit du, input int md, input int lo, input int hi,
                              input bit stp);
        int elo, ehi;
`ifdef MBIST_ADDR_RANGE_EN
        elo = lo;
        ehi = hi;
`else
        elo = 0;
        ehi = (1 << AW) - 1;
`endif
        if (st) begin
            if (elo > ehi) begin
                m_busy = 0;
                m_done = 1;
                m_err  = 1;
            end else begin
                m_seq.delete();
                if (du) for (int i = elo; i <= ehi; i++) m_seq.push_back(i);
                else    for (int i = ehi; i >= elo; i--) m_seq.push_back(i);
                m_pos  = 0;
                m_mode = md;
                m_addr = ref_map(md, m_seq[0]);
                m_busy = 1;
                m_done = 0;
                m_err  = 0;
            end
        end else if (stp && m_busy) begin
            if (m_pos == m_seq.size() - 1) begin
                m_busy = 0;
                m_done = 1;
            end else begin
                m_pos++;
                m_addr = ref_map(m_mode, m_seq[m_pos]);
            end
        end
    endtask

    function automatic logic [7:0] model_vec();
        logic [3:0] a;
        bit         last;
        a    = 4'(m_addr);
        last = m_busy && (m_pos == m_seq.size() - 1);
        return {a, m_busy, m_done, last, m_err};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {addr, busy, sweep_done, last_addr, range_err};
    endfunction

    // One clock: drive on the falling edge, advance the model at the rising edge, compare 1 time unit later.
    task automatic tick(input bit st, input bit du, input logic [1:0] md, input logic [AW-1:0] lo,
                        input logic [AW-1:0] hi, input bit stp, input string name);
        @(negedge clk);
        start_elem = st;
        dir_up     = du;
        mode       = md;
        addr_lo    = lo;
        addr_hi    = hi;
        addr_step  = stp;
        @(posedge clk);
        model_edge(st, du, int'(md), int'(lo), int'(hi), stp);
        #1;
        check(name, 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic step(input string name);
        tick(1'b0, 1'b0, 2'b00, 4'd0, 4'd0, 1'b1, name);
    endtask

    typedef struct {
        bit       st;
        bit       du;
        bit [1:0] md;
        bit [3:0] lo;
        bit [3:0] hi;
        bit       stp;
        bit [7:0] exp;   // {addr, busy, sweep_done, last_addr, range_err}
    } vec_t;

    vec_t tbl[9];
    int   rf_seq[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    initial begin
`ifdef MBIST_ADDR_RANGE_EN
        tbl[0] = '{1'b1, 1'b0, 2'd2, 4'd1, 4'd3, 1'b0, 8'h28};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'h38};
        tbl[2] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'h1A};
        tbl[3] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'h14};
        tbl[4] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'h14};
        tbl[5] = '{1'b1, 1'b1, 2'd0, 4'd9, 4'd4, 1'b0, 8'h15};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'h15};
        tbl[7] = '{1'b1, 1'b1, 2'd0, 4'd2, 4'd2, 1'b0, 8'h2A};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'h24};
`else
        tbl[0] = '{1'b1, 1'b1, 2'd0, 4'd5, 4'd6, 1'b0, 8'h08};
        tbl[1] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'h18};
        tbl[2] = '{1'b1, 1'b1, 2'd0, 4'd9, 4'd4, 1'b0, 8'h08};
        tbl[3] = '{1'b1, 1'b0, 2'd2, 4'd1, 4'd3, 1'b0, 8'h88};
        tbl[4] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'h98};
        tbl[5] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'hB8};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'hA8};
        tbl[7] = '{1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 8'hE8};
        tbl[8] = '{1'b1, 1'b1, 2'd1, 4'd0, 4'd0, 1'b0, 8'h08};
`endif

        reset_n    = 1'b0;
        start_elem = 1'b0;
        dir_up     = 1'b0;
        mode       = 2'b00;
        addr_lo    = '0;
        addr_hi    = '0;
        addr_step  = 1'b0;
        model_reset();
        #3;
        check("reset_state", 32'(dut_vec()), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        step("step_after_reset_ignored");
        check("idle_after_reset", 32'(dut_vec()), 32'h0);

        // Gray-down / range error / single-address vectors.
        for (int i = 0; i < 9; i++) begin
            tick(tbl[i].st, tbl[i].du, tbl[i].md, tbl[i].lo, tbl[i].hi, tbl[i].stp, $sformatf("tbl%0d_model", i));
            check($sformatf("tbl%0d_const", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end

        // Linear up over the full range: no wrap past 15.
        tick(1'b1, 1'b1, 2'b00, 4'd0, 4'd15, 1'b0, "lin_start");
        check("lin_addr0", 32'(addr), 32'd0);
        for (int k = 1; k < 16; k++) begin
            step($sformatf("lin_step%0d", k));
            check($sformatf("lin_addr%0d", k), 32'({addr, last_addr}), 32'({4'(k), k == 15}));
        end
        step("lin_step16");
        check("lin_done", 32'(dut_vec()), 32'({4'd15, 4'b0100}));
        step("lin_extra");
        check("lin_hold", 32'(addr), 32'd15);

        // Row-fast up over the full range.
        tick(1'b1, 1'b1, 2'b01, 4'd0, 4'd15, 1'b0, "rf_start");
        check("rf_addr0", 32'(addr), 32'(rf_seq[0]));
        for (int k = 1; k < 16; k++) begin
            step($sformatf("rf_step%0d", k));
            check($sformatf("rf_addr%0d", k), 32'(addr), 32'(rf_seq[k]));
        end

        // Start with a simultaneous step mid-sweep: restart wins.
        tick(1'b1, 1'b1, 2'b00, 4'd2, 4'd12, 1'b0, "rs_start");
        step("rs_s1");
        step("rs_s2");
        tick(1'b1, 1'b0, 2'b10, 4'd3, 4'd10, 1'b1, "rs_restart");
`ifdef MBIST_ADDR_RANGE_EN
        check("rs_restart_addr", 32'(addr), 32'(10 ^ 5));
`else
        check("rs_restart_addr", 32'(addr), 32'(15 ^ 7));
`endif

        // Asynchronous reset mid-sweep, then steps ignored until a new start.
        step("rst_pre");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_async", 32'(dut_vec()), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step("rst_step_ignored");
        step("rst_step_ignored2");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            tick($urandom_range(0, 7) == 0, 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mbist_addrseq.md
MBIST_ADDRSEQ -- requirements
Module: mbist_addrseq

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the address width (>=2).
REQ-002 Parameter COL_WIDTH, default 3, SHALL set the low column-field width (1..ADDR_WIDTH-1); row width R = ADDR_WIDTH-COL_WIDTH.
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start_elem  input  1  SHALL be a pulse that starts a new march element.
REQ-006 dir_up  input  1  SHALL select sweep direction, 1=up, 0=down, sampled on start_elem.
REQ-007 mode  input  2  SHALL select the order, sampled on start_elem: 00 linear, 01 row-fast, 10 gray, 11 reserved (treated as linear).
REQ-008 addr_lo / addr_hi  input  ADDR_WIDTH each  SHALL be the inclusive index bounds, sampled on start_elem.
REQ-009 addr_step  input  1  SHALL be a pulse that advances one address.
REQ-010 addr  output  ADDR_WIDTH  SHALL be the registered physical address.
REQ-011 sweep_done  output  1  SHALL be a sticky flag: element complete.
REQ-012 busy  output  1  SHALL be high while an element is in progress.
REQ-013 last_addr  output  1  SHALL be high while busy and the index equals the end bound.
REQ-014 range_err  output  1  SHALL be a sticky flag: addr_lo > addr_hi at start.

Function
REQ-015 The block SHALL hold an ADDR_WIDTH-bit index idx, with addr = map(idx) registered in the same cycle that idx updates.
REQ-016 map SHALL be: linear addr=idx; row-fast addr={idx[R-1:0], idx[ADDR_WIDTH-1:R]}; gray addr=idx^(idx>>1).
REQ-017 Start bound SHALL be lo for dir_up=1 and hi otherwise; end bound SHALL be the opposite.
REQ-018 On start_elem with lo<=hi, the next edge SHALL load idx=start bound and addr=map(start), set busy=1, and clear sweep_done and range_err.
REQ-019 On start_elem with lo>hi, the next edge SHALL set busy=0, sweep_done=1, range_err=1, and leave idx and addr unchanged.
REQ-020 On addr_step while busy with idx!=end, idx SHALL move by +1 (up) or -1 (down) and addr SHALL update on that edge (latency 1).
REQ-021 On addr_step while busy with idx==end, sweep_done SHALL go to 1, busy to 0, and idx and addr SHALL hold.
REQ-022 addr_step while not busy SHALL be ignored.
REQ-023 start_elem SHALL take priority over a simultaneous addr_step.
REQ-024 start_elem while busy SHALL restart the element per REQ-018/019.
REQ-025 Arithmetic SHALL never wrap: with lo=0 and hi=all-ones, the sweep SHALL end at the bound without overflow.
REQ-026 lo==hi SHALL give a one-address element: last_addr=1 immediately, and the first addr_step SHALL complete it.
REQ-027 mode, dir_up and the bounds SHALL be ignored except when sampled on start_elem.

Reset
REQ-028 When reset_n is low, the block SHALL clear idx, addr, sweep_done, busy, range_err and last_addr to 0 regardless of clk.
REQ-029 Reset mid-element SHALL abandon the element, and no step SHALL take effect until the next start_elem.

Configuration
REQ-030 When MBIST_ADDR_RANGE_EN is defined, addr_lo and addr_hi SHALL be used per REQ-008..019.
REQ-031 When MBIST_ADDR_RANGE_EN is undefined, the ports SHALL remain but be ignored: lo=0, hi=all-ones, and range_err tied 0.

Verification (ADDR_WIDTH=4, COL_WIDTH=2, macro defined unless noted)
REQ-032 Linear up, lo=0, hi=15, 16 steps -> addr 0..15 one per step, last_addr at 15, sweep_done after the 16th step, addr holds 15.
REQ-033 Row-fast up, full range -> addr sequence 0,4,8,12,1,5,9,13,...,15.
REQ-034 Gray down, lo=1, hi=3 -> addr 2,3,1 (idx 3,2,1), then sweep_done; extra steps leave addr at 1.
REQ-035 lo=9, hi=4 start -> range_err=1, sweep_done=1, busy=0; a later valid start clears both.
REQ-036 start_elem and addr_step in the same cycle mid-sweep -> restart wins (addr=map(start)); reset_n low mid-sweep -> all outputs 0 asynchronously.
REQ-037 Macro undefined, lo=5, hi=6, linear up -> full 0..15 sweep, range_err stays 0.
